// File: rtl/receptor_ascii.sv
// Serial ASCII receiver for "DDD,DDD#" angle/distance messages: 7E1 frames,
// shadow-buffered digits, binary conversion on the closing '#'.
module receptor_ascii #(
    parameter int CICLOS_POR_BIT = 434
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       dado_serial,
    output logic [6:0] centena_angulo,
    output logic [6:0] dezena_angulo,
    output logic [6:0] unidade_angulo,
    output logic [6:0] centena_distancia,
    output logic [6:0] dezena_distancia,
    output logic [6:0] unidade_distancia,
    output logic [9:0] angulo,
    output logic [9:0] distancia,
    output logic       pronto,
    output logic       erro,
    output logic [2:0] estado
);

    typedef enum logic [2:0] {
        OCIOSO   = 3'd0,
        INICIO   = 3'd1,
        DADOS    = 3'd2,
        PARIDADE = 3'd3,
        PARADA   = 3'd4
    } estado_t;

    localparam int CW = $clog2(CICLOS_POR_BIT + 1);
    localparam logic [CW-1:0] FIM_BIT  = CW'(CICLOS_POR_BIT - 1);
    localparam logic [CW-1:0] MEIO_BIT = CW'(CICLOS_POR_BIT / 2 - 1);

    localparam logic [6:0] ASCII_ZERO    = 7'h30;
    localparam logic [6:0] ASCII_NOVE    = 7'h39;
    localparam logic [6:0] ASCII_VIRGULA = 7'h2C;
    localparam logic [6:0] ASCII_FIM     = 7'h23;

    estado_t       estado_q, estado_d;
    logic [1:0]    sinc;
    logic          rx;
    logic [CW-1:0] contador;
    logic [2:0]    conta_bits;
    logic [6:0]    dados;
    logic          bit_paridade;
    logic          amostra;
    logic          char_pronto;
    logic          char_ok;

    assign rx     = sinc[1];
    assign estado = estado_q;

    always_ff @(posedge clock) begin
        if (reset) sinc <= 2'b11;
        else       sinc <= {sinc[0], dado_serial};
    end

    // amostra marks the sampling instant of the current bit (mid-bit).
    always_comb begin
        estado_d    = estado_q;
        amostra     = 1'b0;
        char_pronto = 1'b0;
        case (estado_q)
            OCIOSO: begin
                if (!rx) estado_d = INICIO;
            end
            INICIO: begin
                if (contador == MEIO_BIT) begin
                    amostra  = 1'b1;
                    estado_d = rx ? OCIOSO : DADOS;
                end
            end
            DADOS: begin
                if (contador == FIM_BIT) begin
                    amostra = 1'b1;
                    if (conta_bits == 3'd6) estado_d = PARIDADE;
                end
            end
            PARIDADE: begin
                if (contador == FIM_BIT) begin
                    amostra  = 1'b1;
                    estado_d = PARADA;
                end
            end
            PARADA: begin
                if (contador == FIM_BIT) begin
                    amostra     = 1'b1;
                    char_pronto = 1'b1;
                    estado_d    = OCIOSO;
                end
            end
            default: estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado_q     <= OCIOSO;
            contador     <= '0;
            conta_bits   <= '0;
            dados        <= '0;
            bit_paridade <= 1'b0;
        end else begin
            estado_q <= estado_d;
            if (estado_q == OCIOSO || amostra) contador <= '0;
            else                               contador <= contador + 1'b1;
            if (estado_q == INICIO && amostra) conta_bits <= '0;
            if (estado_q == DADOS && amostra) begin
                dados      <= {rx, dados[6:1]};
                conta_bits <= conta_bits + 1'b1;
            end
            if (estado_q == PARIDADE && amostra) bit_paridade <= rx;
        end
    end

    // Even parity over data+parity, and the stop sample is the live line value.
    assign char_ok = ~(^{dados, bit_paridade}) & rx;

    // ---------------- message parser ----------------
    logic [2:0] posicao;
    logic [6:0] sombra [0:6];
    logic [6:0] esperado_fixo;
    logic       eh_digito;
    logic       char_esperado;

    assign eh_digito = (dados >= ASCII_ZERO) && (dados <= ASCII_NOVE);

    always_comb begin
        esperado_fixo = ASCII_ZERO;
        char_esperado = eh_digito;
        if (posicao == 3'd3) begin
            esperado_fixo = ASCII_VIRGULA;
            char_esperado = (dados == ASCII_VIRGULA);
        end else if (posicao == 3'd7) begin
            esperado_fixo = ASCII_FIM;
            char_esperado = (dados == ASCII_FIM);
        end
    end

    function automatic logic [9:0] para_binario(input logic [6:0] c,
                                                input logic [6:0] d,
                                                input logic [6:0] u);
        logic [9:0] vc, vd, vu;
        vc = {3'b000, c - ASCII_ZERO};
        vd = {3'b000, d - ASCII_ZERO};
        vu = {3'b000, u - ASCII_ZERO};
        return vc * 10'd100 + vd * 10'd10 + vu;
    endfunction

    // pronto/erro are single-cycle strobes with no handshake: a consumer that
    // is not watching on that cycle simply reads the held digit outputs later.
    always_ff @(posedge clock) begin
        if (reset) begin
            posicao           <= '0;
            pronto            <= 1'b0;
            erro              <= 1'b0;
            centena_angulo    <= ASCII_ZERO;
            dezena_angulo     <= ASCII_ZERO;
            unidade_angulo    <= ASCII_ZERO;
            centena_distancia <= ASCII_ZERO;
            dezena_distancia  <= ASCII_ZERO;
            unidade_distancia <= ASCII_ZERO;
            angulo            <= '0;
            distancia         <= '0;
            for (int i = 0; i < 7; i++) sombra[i] <= ASCII_ZERO;
        end else begin
            pronto <= 1'b0;
            erro   <= 1'b0;
            if (char_pronto) begin
                if (!char_ok || !char_esperado) begin
                    erro    <= 1'b1;
                    posicao <= '0;
                end else if (posicao == 3'd7) begin
                    pronto            <= 1'b1;
                    posicao           <= '0;
                    centena_angulo    <= sombra[0];
                    dezena_angulo     <= sombra[1];
                    unidade_angulo    <= sombra[2];
                    centena_distancia <= sombra[4];
                    dezena_distancia  <= sombra[5];
                    unidade_distancia <= sombra[6];
                    angulo            <= para_binario(sombra[0], sombra[1], sombra[2]);
                    distancia         <= para_binario(sombra[4], sombra[5], sombra[6]);
                end else begin
                    sombra[posicao] <= (posicao == 3'd3) ? esperado_fixo : dados;
                    posicao         <= posicao + 1'b1;
                end
            end
        end
    end

endmodule

// File: doc/receptor_ascii.md
RECEPTOR_ASCII -- requirements
Module: receptor_ascii

Interface
REQ-001 Parameter CICLOS_POR_BIT, default 434, clock cycles per serial bit (50 MHz clock, 115200 baud) SHALL be provided.
REQ-002 clock  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 dado_serial  input  1  asynchronous serial line, idle high; SHALL pass through a 2-flop synchronizer before use.
REQ-005 centena_angulo, dezena_angulo, unidade_angulo  output  7 each  ASCII digits of the last valid angle.
REQ-006 centena_distancia, dezena_distancia, unidade_distancia  output  7 each  ASCII digits of the last valid distance.
REQ-007 angulo, distancia  output  10 each  binary value of the corresponding 3 digits (0-999).
REQ-008 pronto  output  1  one-cycle pulse on each accepted message.
REQ-009 erro  output  1  one-cycle pulse on each rejected character.

Function -- serial character receiver
REQ-010 Frame SHALL be: start bit 0, 7 data bits LSB first, even parity bit, 1 stop bit 1.
REQ-011 Bit FSM states SHALL be OCIOSO, INICIO, DADOS, PARIDADE, PARADA.
REQ-012 OCIOSO -> INICIO on synchronized line = 0.
REQ-013 INICIO: after CICLOS_POR_BIT/2 cycles, line sampled; if 1 -> OCIOSO with no error (glitch); if 0 -> DADOS.
REQ-014 DADOS: sample every CICLOS_POR_BIT cycles; 7 samples -> PARIDADE.
REQ-015 PARIDADE: one sample after CICLOS_POR_BIT cycles -> PARADA.
REQ-016 PARADA: one sample after CICLOS_POR_BIT cycles; then character complete; state -> OCIOSO in the same cycle.
REQ-017 Character valid iff XOR of the 7 data bits and the parity bit = 0 and stop sample = 1; otherwise character invalid.

Function -- message parser
REQ-018 Message SHALL be exactly 8 characters: D D D ',' D D D '#', D in 7'h30-7'h39, ',' = 7'h2C, '#' = 7'h23.
REQ-019 Position counter 0-7 SHALL advance by one on each valid, expected character.
REQ-020 Characters SHALL be held in shadow registers; outputs SHALL stay unchanged until a full message is accepted.
REQ-021 Invalid character (parity/stop failure) or unexpected value at its position SHALL pulse erro the cycle after the stop sample and reset position to 0.
REQ-022 Exception: unexpected '#' SHALL pulse erro and reset position to 0 (resynchronization point).
REQ-023 Valid '#' at position 7: all 6 digit outputs, angulo and distancia SHALL update and pronto SHALL pulse, both in the cycle after the stop sample; position -> 0.
REQ-024 Binary conversion: value = 100*centena + 10*dezena + unidade using (char - 7'h30), 10-bit result, computed from shadow registers before the update.
REQ-025 pronto and erro SHALL never be asserted in the same cycle; each is high for exactly one cycle.
REQ-026 Back-to-back frames (start bit immediately after stop bit) SHALL be received with no lost character.

Reset
REQ-027 Reset SHALL force bit FSM to OCIOSO, position to 0, counters to 0, pronto = 0, erro = 0.
REQ-028 Reset SHALL set all digit outputs to 7'h30 and angulo = distancia = 10'd0.
REQ-029 Reset asserted mid-character or mid-message SHALL discard all partial data; a new message starting after reset release SHALL be received normally.
REQ-030 Synchronizer flops SHALL reset to 1 (idle line).

Verification
REQ-031 Send "123,045#" with correct parity -> one pronto pulse; digits 7'h31,7'h32,7'h33 / 7'h30,7'h34,7'h35; angulo = 123, distancia = 45; erro never high.
REQ-032 Send "090,1" then character '2' with wrong parity, then "090,120#" -> one erro pulse; outputs unchanged until second message; then angulo = 90, distancia = 120, one pronto.
REQ-033 Send "1A" -> erro pulse after 'A'; then "999,999#" -> angulo = 999, distancia = 999, one pronto.
REQ-034 Drive line low for CICLOS_POR_BIT/4 cycles then high -> no erro, no pronto, FSM back in OCIOSO; next "000,000#" accepted.
REQ-035 Assert reset for 1 cycle during 6th character of a message -> outputs 7'h30 / 0; remaining characters plus "045,300#" -> one erro at the stray '#', then one pronto with angulo = 45, distancia = 300.
REQ-036 Two messages back-to-back with zero idle between frames -> two pronto pulses, final values from the second message.
